// File: rtl/uart_tx_ctrl.sv
// UART transmit controller.
// Sequences one frame per accepted word: start bit, DATA_WIDTH data bits
// taken from an external serializer (LSB first), an optional parity bit and
// one stop bit. One clk cycle is one bit period. A new word may be accepted
// in the stop cycle, so frames can run back-to-back without an idle gap.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_load,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  accept
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;

    // Frame configuration captured at accept; later host changes are ignored
    // until the next word is taken.
    logic par_en_q;
    logic par_bit_q;

    // Window in which a host word can be taken: idle, or the stop bit of the
    // previous frame (back-to-back transmission).
    logic load_window;

    // Parity bit of a word: XOR reduction gives even parity, inverting it
    // gives odd parity.
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  odd);
        return (^word) ^ odd;
    endfunction

    assign load_window = data_valid && ((state == IDLE) || (state == STOP));

    // The state register reads IDLE while rst is low, so the handshake is
    // gated explicitly to keep it quiet during reset.
    assign accept   = rst && load_window;
    assign ser_load = accept;

    // Frame sequencer: state, busy flag and latched frame configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            if (load_window) begin
                par_en_q  <= par_en;
                par_bit_q <= parity_of(p_data, par_typ);
            end

            case (state)
                IDLE: begin
                    if (data_valid) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= DATA;
                end
                DATA: begin
                    // ser_done marks the cycle carrying the last data bit,
                    // so the frame moves on at the end of that cycle.
                    if (ser_done) begin
                        state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state <= STOP;
                end
                STOP: begin
                    if (data_valid) begin
                        state <= START;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Line driver: pure decode of the current bit, no extra register stage.
    always_comb begin
        tx_out = 1'b1;
        case (state)
            IDLE:    tx_out = 1'b1;
            START:   tx_out = 1'b0;
            DATA:    tx_out = ser_data;
            PARITY:  tx_out = par_bit_q;
            STOP:    tx_out = 1'b1;
            default: tx_out = 1'b1;
        endcase
    end

    // Serializer shift enable: the start cycle shifts out bit 0, then each
    // data cycle advances until the serializer reports its last bit.
    always_comb begin
        ser_en = 1'b0;
        if (state == START) begin
            ser_en = 1'b1;
        end else if ((state == DATA) && !ser_done) begin
            ser_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: each accepted word pushes its expected
// line bits into a queue; a monitor on the falling edge pops one entry per
// busy cycle and compares line, shift enable and handshake.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         par_en;
    logic         par_typ;
    logic         ser_data;
    logic         ser_done;
    logic         ser_load;
    logic         ser_en;
    logic         tx_out;
    logic         busy;
    logic         accept;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic val;   // expected line level
        logic last;  // stop bit: a new word may be taken here
        logic en;    // expected serializer shift enable
    } exp_t;

    exp_t q[$];

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_load   (ser_load),
        .ser_en     (ser_en),
        .tx_out     (tx_out),
        .busy       (busy),
        .accept     (accept)
    );

    always #5 clk = ~clk;

    // Serializer model: loads on ser_load, presents one registered bit per
    // ser_en, reports done once all W bits have been presented.
    logic [W-1:0] sh;
    int           cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh       <= '0;
            cnt      <= W;
            ser_data <= 1'b0;
        end else if (ser_load) begin
            sh  <= p_data;
            cnt <= 0;
        end else if (ser_en) begin
            ser_data <= sh[0];
            sh       <= sh >> 1;
            cnt      <= cnt + 1;
        end
    end
    assign ser_done = (cnt == W);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        logic p;
        q.push_back('{val: 1'b0, last: 1'b0, en: 1'b1});
        for (int i = 0; i < W; i++)
            q.push_back('{val: d[i], last: 1'b0, en: (i != W - 1)});
        if (pe) begin
            p = logic'($countones(d) % 2) ^ pt;
            q.push_back('{val: p, last: 1'b0, en: 1'b0});
        end
        q.push_back('{val: 1'b1, last: 1'b1, en: 1'b0});
    endtask

    // Offer a word (starting right now, just after a rising edge) and play
    // out its frame; returns in the stop cycle, just after the rising edge.
    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt, input bit noise);
        bit ok;
        int len;
        data_valid = 1'b1;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (accept) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout at %0t: got no accept, expected accept", $time);
            data_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_frame(d, pe, pt);
        #1;
        len = 1 + W + (pe ? 1 : 0) + 1;
        for (int i = 0; i < len - 1; i++) begin
            if (noise) begin
                data_valid = 1'($urandom_range(0, 1));
                p_data     = W'($urandom);
                par_en     = 1'($urandom_range(0, 1));
                par_typ    = 1'($urandom_range(0, 1));
            end else begin
                data_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: one scoreboard entry per busy cycle, idle line otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_tx_out", tx_out, 1);
                chk("rst_busy", busy, 0);
                chk("rst_accept", accept, 0);
                chk("rst_ser_en", ser_en, 0);
            end else if (busy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_overrun at %0t: got busy=1, expected idle", $time);
                end else begin
                    e = q.pop_front();
                    chk("tx_out", tx_out, e.val);
                    chk("ser_en", ser_en, e.en);
                    chk("accept", accept, data_valid && e.last);
                    chk("ser_load", ser_load, data_valid && e.last);
                end
            end else begin
                chk("frame_pending", q.size(), 0);
                chk("idle_tx_out", tx_out, 1);
                chk("idle_ser_en", ser_en, 0);
                chk("idle_accept", accept, data_valid);
                chk("idle_ser_load", ser_load, data_valid);
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        // Reset state, with data_valid offered to show the handshake is gated.
        rst        = 1'b0;
        data_valid = 1'b1;
        p_data     = 8'h3C;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        #12;
        chk("reset_tx_out", tx_out, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ser_en", ser_en, 0);
        chk("reset_accept", accept, 0);
        chk("reset_ser_load", ser_load, 0);
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Plain frame, then even and odd parity frames on 0xA5.
        send(8'hA5, 1'b0, 1'b0, 0);
        idle(2);
        send(8'hA5, 1'b1, 1'b0, 0);
        idle(1);
        send(8'hA5, 1'b1, 1'b1, 0);
        idle(2);

        // Back-to-back: the second word is offered during the first stop bit.
        send(8'h01, 1'b1, 1'b1, 0);
        send(8'hFF, 1'b1, 1'b0, 0);
        idle(2);

        // Host noise (data_valid pulses, config flips) inside the frame.
        send(8'h5A, 1'b1, 1'b1, 1);
        idle(1);
        send(8'hC3, 1'b0, 1'b0, 1);
        idle(2);

        // Reset during the fourth data bit, then a clean frame.
        d          = W'($urandom) & 8'hF7;
        data_valid = 1'b1;
        p_data     = d;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        @(negedge clk);
        chk("pre_reset_accept", accept, 1);
        @(posedge clk);
        push_frame(d, 1'b1, 1'b0);
        #1;
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_frame_busy_before", busy, 1);
        rst = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_tx_out", tx_out, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ser_en", ser_en, 0);
        chk("mid_rst_accept", accept, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(8'h96, 1'b1, 1'b1, 0);
        idle(2);

        // Randomized frames with random gaps (zero gap = back-to-back).
        for (int n = 0; n < 40; n++) begin
            send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        idle(3);
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the parallel data word and of the parity computation.
REQ-002 clk  input  1  clock; one clk cycle equals one UART bit period.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 p_data  input  DATA_WIDTH  parallel word offered by the host.
REQ-005 data_valid  input  1  host offers p_data this cycle.
REQ-006 par_en  input  1  1 = a parity bit is inserted after the data bits.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 ser_data  input  1  registered serial bit from the serializer.
REQ-009 ser_done  input  1  serializer has presented its last data bit.
REQ-010 ser_load  output  1  load strobe to the serializer's data_valid input.
REQ-011 ser_en  output  1  shift enable to the serializer.
REQ-012 tx_out  output  1  UART line output, idle high.
REQ-013 busy  output  1  a frame is in progress.
REQ-014 accept  output  1  p_data is taken this cycle.

Function
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, and SHALL be registered on clk.
REQ-016 The block SHALL assert accept = ser_load = data_valid only in IDLE or STOP; both SHALL be 0 in every other state.
REQ-017 On accept, the block SHALL latch par_en, par_typ and the parity of p_data (XOR reduction, XNOR for odd parity), and SHALL move to START.
REQ-018 In IDLE without data_valid, the block SHALL remain in IDLE.
REQ-019 START SHALL last exactly 1 cycle, with tx_out = 0; it SHALL always be followed by DATA.
REQ-020 ser_en SHALL be 1 in START, and in DATA while ser_done = 0; otherwise ser_en SHALL be 0.
REQ-021 In DATA, tx_out SHALL equal ser_data; the block SHALL leave DATA in the cycle after the one in which ser_done = 1, because that cycle carries the last data bit.
REQ-022 DATA SHALL last exactly DATA_WIDTH cycles, presenting LSB first.
REQ-023 On leaving DATA, the next state SHALL be PARITY if the latched par_en = 1, else STOP.
REQ-024 PARITY SHALL last 1 cycle with tx_out = the latched parity bit, followed by STOP.
REQ-025 STOP SHALL last 1 cycle with tx_out = 1.
REQ-026 From STOP, the block SHALL go to START if data_valid = 1 (back-to-back frame, no idle gap), else to IDLE.
REQ-027 In IDLE, tx_out SHALL be 1.
REQ-028 tx_out SHALL be a combinational decode of state, ser_data and the latched parity; there SHALL be no extra register stage.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Frame length SHALL be 1 + DATA_WIDTH + par_en + 1 cycles, measured from the first START cycle.
REQ-031 data_valid in START, DATA or PARITY SHALL be ignored: no load and no state change, and the host SHALL hold data until accept.
REQ-032 Changes to par_en or par_typ mid-frame SHALL NOT affect the frame in progress.
REQ-033 If ser_done does not assert, the FSM SHALL remain in DATA; a timeout is out of scope.

Reset
REQ-034 While rst = 0, the block SHALL force: state = IDLE, tx_out = 1, busy = 0, ser_en = 0, ser_load = 0, accept = 0, latched parity/config = 0.
REQ-035 Reset asserted mid-frame SHALL return the block to IDLE immediately (asynchronously), with the line high; no partial stop bit SHALL be emitted.
REQ-036 After rst deasserts, the first accept SHALL be possible on the first clk edge.

Verification
REQ-037 Scenario 1: p_data = 0xA5, par_en = 0, one-cycle data_valid in IDLE -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles), then idle high; busy high for exactly 10 cycles.
REQ-038 Scenario 2: p_data = 0xA5, par_en = 1, par_typ = 0 -> parity bit 0, 11-cycle frame; with par_typ = 1 -> parity bit 1.
REQ-039 Scenario 3: p_data = 0x01 with odd parity, then 0xFF with even parity, with data_valid held through the STOP cycle -> second START immediately follows STOP; both parity bits = 0; there SHALL be no idle-high gap between the frames.
REQ-040 Scenario 4: data_valid pulsed during DATA and PARITY -> accept = 0, ser_load = 0, and the frame bits are unchanged.
REQ-041 Scenario 5: rst driven low during the fourth data bit -> within the same cycle tx_out = 1, busy = 0, ser_en = 0; the next accept produces a clean full frame.
REQ-042 Scenario 6: par_en toggled mid-frame after accepting with par_en = 0 -> no parity bit; frame length stays 10.
